// File: rtl/onehot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_seq_pkg
// Brief    : Shared command encodings and state encodings for onehot_decoder_seq.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/decoder_param.sv
`default_nettype none
// ============================================================================
// Module   : decoder_param
// Brief    : Combinational IN_W-to-OUT_N one-hot decoder with out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_param #(
  parameter int IN_W  = 3,
  parameter int OUT_N = 8
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_N-1:0] dec_o,
  output logic             oor_o
);

  // An out-of-range index matches no output bit, so dec_o is zero then.
  for (genvar g = 0; g < OUT_N; g++) begin : g_dec
    assign dec_o[g] = (in_i == IN_W'(g));
  end

  if (OUT_N < (1 << IN_W)) begin : g_partial
    assign oor_o = (in_i >= IN_W'(OUT_N));
  end else begin : g_full
    assign oor_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder_seq
// Brief    : Registered one-hot select with load, rotate-left/right and sticky
//            out-of-range error flag.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decoder_seq #(
  parameter int IN_W  = 3,
  parameter int OUT_N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  in_i,
  input  logic             err_clr_i,
  output logic [OUT_N-1:0] out_o,
  output logic [IN_W-1:0]  idx_o,
  output logic             valid_o,
  output logic             err_o
);

  import onehot_seq_pkg::*;

  if (IN_W < 1 || IN_W > 6) begin : g_chk_in_w
    $error("onehot_decoder_seq: IN_W must be in 1..6");
  end
  if (OUT_N < 2 || OUT_N > (1 << IN_W)) begin : g_chk_out_n
    $error("onehot_decoder_seq: OUT_N must be in 2..2**IN_W");
  end

  localparam logic [IN_W-1:0] IDX_MAX = IN_W'(OUT_N - 1);

  logic [0:0]       state_q, state_d;
  logic [OUT_N-1:0] sel_q, sel_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic             err_q, err_d;

  logic [OUT_N-1:0] w_dec;
  logic             w_oor;
  logic             w_err_set;

  decoder_param #(
    .IN_W  (IN_W),
    .OUT_N (OUT_N)
  ) u_dec (
    .in_i  (in_i),
    .dec_o (w_dec),
    .oor_o (w_oor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      sel_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    w_err_set = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_LOAD: begin
          if (w_oor) begin
            state_d   = ST_EMPTY;
            sel_d     = '0;
            idx_d     = '0;
            w_err_set = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
            sel_d   = w_dec;
            idx_d   = in_i;
          end
        end
        MODE_ROTL: begin
          if (state_q == ST_ACTIVE) begin
            sel_d = {sel_q[OUT_N-2:0], sel_q[OUT_N-1]};
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IN_W'(1);
          end
        end
        MODE_ROTR: begin
          if (state_q == ST_ACTIVE) begin
            sel_d = {sel_q[0], sel_q[OUT_N-1:1]};
            idx_d = (idx_q == '0) ? IDX_MAX : idx_q - IN_W'(1);
          end
        end
        default: ;
      endcase
    end
    // A new error outranks a simultaneous clear.
    err_d = w_err_set | (err_q & ~err_clr_i);
  end

  always_comb begin
    out_o   = sel_q;
    idx_o   = idx_q;
    valid_o = (state_q == ST_ACTIVE);
    err_o   = err_q;
  end

endmodule
`default_nettype wire
